// File: rtl/pwm_voice_scheduler.sv
// Purpose: round-robin scheduler sharing one PWM tone generator among drum-pad hit requesters.
// Latency: hit sampled at edge k -> grant at k+1 -> restart (LOAD) cycle -> pwm_en high after k+2.
// Backpressure: none; repeat hits merge into one pending bit per pad until that pad is served.
module pwm_voice_scheduler #(
  parameter int NUM_PADS    = 4,
  parameter int TOP_W       = 16,
  parameter int NOTE_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 1000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_PADS-1:0]           i_hit_req,
  input  logic [NUM_PADS*TOP_W-1:0]     i_pad_top,
  input  logic                          i_mute,
  output logic [TOP_W-1:0]              o_pwm_top,
  output logic                          o_pwm_en,
  output logic                          o_pwm_restart,
  output logic [$clog2(NUM_PADS)-1:0]   o_active_pad,
  output logic                          o_busy,
  output logic                          o_note_done,
  output logic                          o_skip_err
);

  localparam int PTR_W    = $clog2(NUM_PADS);
  localparam int DUR_W    = $clog2(NOTE_CYCLES + 1);
  localparam int GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int GAP_INIT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(NOTE_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_INIT);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY, ST_GAP} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_PADS-1:0] r_pending, w_grant_clr;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_nxt;
  logic [PTR_W-1:0]   r_active_pad, w_active_nxt;
  logic [TOP_W-1:0]   r_pwm_top, w_top_nxt;
  logic               r_pwm_en, w_en_nxt;
  logic [DUR_W-1:0]   r_dur_cnt, w_dur_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
  logic               r_note_done, w_note_done_nxt;
  logic               r_skip_err, w_skip_nxt;

  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  int                 w_idx;
  logic [TOP_W-1:0]   w_top_arr [NUM_PADS];
  logic [TOP_W-1:0]   w_sel_top;

  // Unpack the flat period table into one entry per pad.
  for (genvar g = 0; g < NUM_PADS; g++) begin : g_top
    assign w_top_arr[g] = i_pad_top[g*TOP_W +: TOP_W];
  end

  assign w_sel_top = w_top_arr[w_sel];

  // Round-robin pick: first pending pad at or after rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    for (int k = 0; k < NUM_PADS; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_PADS) w_idx = w_idx - NUM_PADS;
      if (!w_found && r_pending[PTR_W'(w_idx)]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(w_idx);
      end
    end
  end

  // Next-state and next-output logic for the grant/play/gap sequence.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_clr     = '0;
    w_rr_nxt        = r_rr_ptr;
    w_active_nxt    = r_active_pad;
    w_top_nxt       = r_pwm_top;
    w_en_nxt        = r_pwm_en;
    w_dur_nxt       = r_dur_cnt;
    w_gap_nxt       = r_gap_cnt;
    w_note_done_nxt = 1'b0;
    w_skip_nxt      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Mute in IDLE only flushes pending, so no grant is taken.
        if (!i_mute && w_found) begin
          w_grant_clr[w_sel] = 1'b1;
          w_active_nxt       = w_sel;
          w_rr_nxt           = (w_sel == PTR_W'(NUM_PADS - 1)) ? '0 : w_sel + PTR_W'(1);
          if (w_sel_top >= TOP_W'(2)) begin
            w_top_nxt   = w_sel_top;
            w_state_nxt = ST_LOAD;
          end else begin
            // Degenerate period: report it and stay idle for the next pad.
            w_skip_nxt = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (i_mute) begin
          w_en_nxt        = 1'b0;
          w_note_done_nxt = 1'b1;
          w_gap_nxt       = GAP_LOAD;
          w_state_nxt     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          w_en_nxt    = 1'b1;
          w_dur_nxt   = DUR_LOAD;
          w_state_nxt = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (i_mute || r_dur_cnt == '0) begin
          w_en_nxt        = 1'b0;
          w_note_done_nxt = 1'b1;
          w_gap_nxt       = GAP_LOAD;
          w_state_nxt     = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          w_dur_nxt = r_dur_cnt - DUR_W'(1);
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
        else                 w_gap_nxt   = r_gap_cnt - GAP_W'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, counters and registered generator controls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_active_pad <= '0;
      r_pwm_top    <= '0;
      r_pwm_en     <= 1'b0;
      r_dur_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_note_done  <= 1'b0;
      r_skip_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_active_pad <= w_active_nxt;
      r_pwm_top    <= w_top_nxt;
      r_pwm_en     <= w_en_nxt;
      r_dur_cnt    <= w_dur_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_note_done  <= w_note_done_nxt;
      r_skip_err   <= w_skip_nxt;
    end
  end

  // Pending hits: a new hit on the grant edge survives the clear; mute flushes everything.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_pending <= '0;
    else if (i_mute) r_pending <= '0;
    else             r_pending <= (r_pending & ~w_grant_clr) | i_hit_req;
  end

  assign o_pwm_top     = r_pwm_top;
  assign o_pwm_en      = r_pwm_en;
  assign o_pwm_restart = (r_state == ST_LOAD);
  assign o_active_pad  = r_active_pad;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_note_done   = r_note_done;
  assign o_skip_err    = r_skip_err;

endmodule

// File: tb/tb_pwm_voice_scheduler.sv
// Bench for pwm_voice_scheduler: directed scenarios plus randomized hits against a slot-based model.
// Timing: inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// The model schedules whole notes (grant edge + fixed slot length) rather than tracking FSM states.
module tb_pwm_voice_scheduler;
  localparam int NP   = 4;
  localparam int TW   = 16;
  localparam int NOTE = 8;
  localparam int GAP  = 2;
  localparam int SLOT = NOTE + GAP + 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [NP-1:0]   hit_req;
  logic [NP*TW-1:0] pad_top;
  logic            mute;
  logic [TW-1:0]   pwm_top;
  logic            pwm_en, pwm_restart, busy, note_done, skip_err;
  logic [1:0]      active_pad;

  int checks = 0;
  int errors = 0;
  int ecnt;
  int q_pad[$];
  int q_top[$];
  int en_cnt, done_cnt, skip_cnt;

  // Reference model state
  bit m_pend[NP];
  int m_rr, m_grant, m_skip, m_free, m_top, m_active;

  always #5 clk = ~clk;

  pwm_voice_scheduler #(
    .NUM_PADS(NP), .TOP_W(TW), .NOTE_CYCLES(NOTE), .GAP_CYCLES(GAP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_hit_req(hit_req), .i_pad_top(pad_top), .i_mute(mute),
    .o_pwm_top(pwm_top), .o_pwm_en(pwm_en), .o_pwm_restart(pwm_restart),
    .o_active_pad(active_pad), .o_busy(busy), .o_note_done(note_done), .o_skip_err(skip_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (pwm_restart) begin
      q_pad.push_back(int'(active_pad));
      q_top.push_back(int'(pwm_top));
    end
    if (pwm_en)    en_cnt++;
    if (note_done) done_cnt++;
    if (skip_err)  skip_cnt++;
  endtask

  task automatic clear_log();
    q_pad.delete();
    q_top.delete();
    en_cnt = 0; done_cnt = 0; skip_cnt = 0;
  endtask

  task automatic set_top(int p, int v);
    pad_top[p*TW +: TW] = TW'(v);
  endtask

  task automatic pulse_hit(logic [NP-1:0] h);
    hit_req = h;
    tick();
    hit_req = '0;
  endtask

  task automatic wait_en(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (pwm_en) ok = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; hit_req = '0; mute = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    ecnt = 0;
    for (int p = 0; p < NP; p++) m_pend[p] = 1'b0;
    m_rr = 0; m_grant = -1000; m_skip = -1000; m_free = 0; m_top = 0; m_active = 0;
  endtask

  // One clock edge of the model: serve at most one pending pad when the voice is free, then merge hits.
  task automatic model_edge(logic [NP-1:0] h, logic [NP*TW-1:0] tops);
    int e, sel, p, t;
    e = ecnt + 1;
    if (e >= m_free) begin
      sel = -1;
      for (int k = 0; k < NP; k++) begin
        p = (m_rr + k) % NP;
        if (sel < 0 && m_pend[p]) sel = p;
      end
      if (sel >= 0) begin
        m_pend[sel] = 1'b0;
        m_active    = sel;
        m_rr        = (sel + 1) % NP;
        t           = int'(tops[sel*TW +: TW]);
        if (t >= 2) begin
          m_top = t; m_grant = e; m_free = e + SLOT;
        end else begin
          m_skip = e; m_free = e + 1;
        end
      end
    end
    for (int q = 0; q < NP; q++) if (h[q]) m_pend[q] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; hit_req = '0; mute = 1'b0; pad_top = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pwm_en !== 1'b0)      begin errors++; $display("FAIL reset_en: got %b expected 0", pwm_en); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (pwm_top !== '0)       begin errors++; $display("FAIL reset_top: got %0d expected 0", pwm_top); end
    checks++; if (active_pad !== 2'd0)  begin errors++; $display("FAIL reset_active: got %0d expected 0", active_pad); end
    checks++; if ({pwm_restart, note_done, skip_err} !== 3'b000)
      begin errors++; $display("FAIL reset_pulses: got %b expected 000", {pwm_restart, note_done, skip_err}); end
    #2;
    rst = 1'b0;
    ecnt = 0;
  endtask

  task automatic test_single_note();
    set_top(1, 100);
    clear_log();
    pulse_hit(4'b0010);
    tick();
    checks++; if (pwm_restart !== 1'b1) begin errors++; $display("FAIL single_restart: got %b expected 1", pwm_restart); end
    checks++; if (pwm_top !== 16'd100)  begin errors++; $display("FAIL single_top: got %0d expected 100", pwm_top); end
    checks++; if (active_pad !== 2'd1)  begin errors++; $display("FAIL single_active: got %0d expected 1", active_pad); end
    checks++; if (pwm_en !== 1'b0)      begin errors++; $display("FAIL single_en_load: got %b expected 0", pwm_en); end
    for (int i = 0; i < NOTE; i++) begin
      tick();
      checks++; if (pwm_en !== 1'b1 || pwm_restart !== 1'b0)
        begin errors++; $display("FAIL single_play[%0d]: en=%b restart=%b expected en=1 restart=0", i, pwm_en, pwm_restart); end
    end
    tick();
    checks++; if (pwm_en !== 1'b0 || note_done !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL single_end: en=%b done=%b busy=%b expected 0 1 1", pwm_en, note_done, busy); end
    tick();
    checks++; if (note_done !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL single_gap: done=%b busy=%b expected 0 1", note_done, busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy=%b expected 0", busy); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_cnt: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_top(0, 10); set_top(1, 20); set_top(2, 30); set_top(3, 40);
    clear_log();
    pulse_hit(4'b1011);
    repeat (45) tick();
    checks++; if (q_pad.size() != 3 || q_pad[0] != 0 || q_pad[1] != 1 || q_pad[2] != 3)
      begin errors++; $display("FAIL rr_order: got %p expected 0,1,3", q_pad); end
    checks++; if (q_top.size() != 3 || q_top[0] != 10 || q_top[1] != 20 || q_top[2] != 40)
      begin errors++; $display("FAIL rr_tops: got %p expected 10,20,40", q_top); end
    checks++; if (en_cnt != 3*NOTE || done_cnt != 3)
      begin errors++; $display("FAIL rr_counts: en=%0d done=%0d expected %0d 3", en_cnt, done_cnt, 3*NOTE); end
    clear_log();
    pulse_hit(4'b1001);
    repeat (30) tick();
    checks++; if (q_pad.size() != 2 || q_pad[0] != 0 || q_pad[1] != 3)
      begin errors++; $display("FAIL rr_wrap: got %p expected 0,3", q_pad); end
  endtask

  task automatic test_rehit();
    bit ok;
    set_top(2, 77);
    for (int nh = 1; nh <= 2; nh++) begin
      clear_log();
      pulse_hit(4'b0100);
      wait_en(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rehit_start: got no pwm_en expected pwm_en within 30 cycles"); end
      for (int j = 0; j < nh; j++) begin
        tick();
        pulse_hit(4'b0100);
      end
      repeat (40) tick();
      checks++; if (q_pad.size() != 2 || q_pad[0] != 2 || q_pad[1] != 2 || done_cnt != 2 || en_cnt != 2*NOTE)
        begin errors++; $display("FAIL rehit_%0d: pads=%p done=%0d en=%0d expected 2,2 2 %0d", nh, q_pad, done_cnt, en_cnt, 2*NOTE); end
    end
  endtask

  task automatic test_skip();
    logic [TW-1:0] prior;
    prior = pwm_top;
    set_top(0, 1); set_top(1, 50);
    clear_log();
    pulse_hit(4'b0011);
    tick();
    checks++; if (skip_err !== 1'b1 || pwm_top !== prior || busy !== 1'b0 || active_pad !== 2'd0)
      begin errors++; $display("FAIL skip_pad0: skip=%b top=%0d busy=%b act=%0d expected 1 %0d 0 0", skip_err, pwm_top, busy, active_pad, prior); end
    tick();
    checks++; if (pwm_restart !== 1'b1 || pwm_top !== 16'd50 || active_pad !== 2'd1 || skip_err !== 1'b0)
      begin errors++; $display("FAIL skip_pad1: rs=%b top=%0d act=%0d skip=%b expected 1 50 1 0", pwm_restart, pwm_top, active_pad, skip_err); end
    repeat (15) tick();
    checks++; if (skip_cnt != 1 || en_cnt != NOTE || q_pad.size() != 1)
      begin errors++; $display("FAIL skip_counts: skip=%0d en=%0d notes=%0d expected 1 %0d 1", skip_cnt, en_cnt, q_pad.size(), NOTE); end
  endtask

  task automatic test_mute();
    bit ok;
    set_top(1, 60); set_top(2, 70);
    clear_log();
    pulse_hit(4'b0010);
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mute_start: got no pwm_en expected pwm_en within 30 cycles"); end
    pulse_hit(4'b0100);
    tick();
    checks++; if (en_cnt != 3) begin errors++; $display("FAIL mute_pre: en=%0d expected 3", en_cnt); end
    mute = 1'b1;
    tick();
    mute = 1'b0;
    checks++; if (pwm_en !== 1'b0 || note_done !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL mute_abort: en=%b done=%b busy=%b expected 0 1 1", pwm_en, note_done, busy); end
    clear_log();
    repeat (2) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mute_idle: busy=%b expected 0", busy); end
    repeat (20) tick();
    checks++; if (q_pad.size() != 0 || en_cnt != 0)
      begin errors++; $display("FAIL mute_flush: notes=%0d en=%0d expected 0 0", q_pad.size(), en_cnt); end
  endtask

  task automatic test_async_reset();
    bit ok;
    set_top(1, 40); set_top(3, 45);
    pulse_hit(4'b0010);
    wait_en(ok);
    checks++; if (!ok) begin errors++; $display("FAIL arst_start: got no pwm_en expected pwm_en within 30 cycles"); end
    pulse_hit(4'b0001);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (pwm_en !== 1'b0 || busy !== 1'b0 || pwm_top !== '0)
      begin errors++; $display("FAIL arst_immediate: en=%b busy=%b top=%0d expected 0 0 0", pwm_en, busy, pwm_top); end
    #2;
    rst = 1'b0;
    clear_log();
    repeat (20) tick();
    checks++; if (q_pad.size() != 0) begin errors++; $display("FAIL arst_pending: notes=%0d expected 0", q_pad.size()); end
    pulse_hit(4'b1010);
    repeat (30) tick();
    checks++; if (q_pad.size() != 2 || q_pad[0] != 1 || q_pad[1] != 3)
      begin errors++; $display("FAIL arst_rr: got %p expected 1,3", q_pad); end
  endtask

  task automatic test_random();
    int e;
    logic exp_en, exp_rs, exp_done, exp_busy, exp_skip;
    apply_reset();
    for (int p = 0; p < NP; p++) set_top(p, $urandom_range(2, 500));
    for (int cyc = 0; cyc < 800; cyc++) begin
      hit_req = ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0;
      if ($urandom_range(0, 29) == 0)
        set_top($urandom_range(0, NP-1), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 500));
      model_edge(hit_req, pad_top);
      tick();
      e        = ecnt;
      exp_rs   = (e == m_grant);
      exp_en   = (e >= m_grant + 1) && (e <= m_grant + NOTE);
      exp_done = (e == m_grant + NOTE + 1);
      exp_busy = (e >= m_grant) && (e <= m_grant + NOTE + GAP);
      exp_skip = (e == m_skip);
      checks++; if ({pwm_restart, pwm_en, note_done, busy, skip_err} !== {exp_rs, exp_en, exp_done, exp_busy, exp_skip})
        begin errors++; $display("FAIL rand_ctrl@%0d: rs/en/done/busy/skip=%b expected %b", e,
          {pwm_restart, pwm_en, note_done, busy, skip_err}, {exp_rs, exp_en, exp_done, exp_busy, exp_skip}); end
      checks++; if (pwm_top !== TW'(m_top) || active_pad !== 2'(m_active))
        begin errors++; $display("FAIL rand_sel@%0d: top=%0d act=%0d expected %0d %0d", e, pwm_top, active_pad, m_top, m_active); end
    end
    hit_req = '0;
  endtask

  initial begin
    test_reset();
    test_single_note();
    test_round_robin();
    test_rehit();
    test_skip();
    test_mute();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_voice_scheduler.md
Name: pwm_voice_scheduler

Overview:
- Shares the single PWM tone generator among NUM_PADS drum-pad hit requesters.
- Latches pad hits and grants the generator round-robin, one pending pad at a time.
- For each grant it loads that pad's period (Top) and restarts the generator, then gates it for a fixed note length followed by a silent gap.
- Sits between the pad-detect logic and the PWM generator, driving its Top and clock-enable inputs.

Parameters:
- NUM_PADS, 4, number of requesting pads (2..8).
- TOP_W, 16, width of the PWM period value.
- NOTE_CYCLES, 50000000, clk cycles pwm_en stays high per note (>=1).
- GAP_CYCLES, 1000, silent clk cycles after each note (0 allowed = no gap).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hit_req  in  NUM_PADS  per-pad hit; level sampled every edge, 1-cycle pulse typical.
- pad_top  in  NUM_PADS*TOP_W  packed period table; pad i at bits [i*TOP_W +: TOP_W].
- mute  in  1  synchronous global mute/abort.
- pwm_top  out  TOP_W  period to generator; held stable from grant until next grant.
- pwm_en  out  1  generator clock-enable.
- pwm_restart  out  1  1-cycle pulse; generator clears its counter/output.
- active_pad  out  clog2(NUM_PADS)  index of last granted pad.
- busy  out  1  high whenever state != IDLE.
- note_done  out  1  1-cycle pulse when a note ends, whether completed or aborted.
- skip_err  out  1  1-cycle pulse when a granted pad has pad_top < 2.

Behaviour:
- Reset, asynchronous:
  - state=IDLE; pending=0; rr_ptr=0; counters=0.
  - pwm_top=0, pwm_en=0, active_pad=0.
  - busy, note_done, skip_err, pwm_restart all 0.
  - Reset mid-note silences the output immediately and drops all pending hits.
- Pending register:
  - pending[i] <= (pending[i] & ~grant_clr[i]) | hit_req[i].
  - A hit on the same edge as that pad's grant clear wins: the bit stays set.
  - A repeat hit while the pad is already pending merges into the one pending bit; no count is kept.
- While mute=1:
  - pending <= 0 and hit_req is ignored.
- States: IDLE, LOAD, PLAY, GAP.
- IDLE, when pending != 0:
  - Select the first set bit scanning rr_ptr, rr_ptr+1, ... and wrapping mod NUM_PADS.
  - On that edge: clear its pending bit; active_pad <= sel; rr_ptr <= (sel+1) mod NUM_PADS.
  - If pad_top[sel] >= 2: pwm_top <= pad_top[sel]; state <= LOAD.
  - Else: skip_err pulses next cycle; pwm_top unchanged; stay in IDLE. The next pad may be granted on the following edge.
- LOAD, one cycle:
  - pwm_restart=1 (Moore output of LOAD).
  - At the edge: pwm_en <= 1; dur_cnt <= NOTE_CYCLES-1; state <= PLAY.
- PLAY:
  - If dur_cnt != 0, decrement each edge.
  - At the edge where dur_cnt == 0: pwm_en <= 0; note_done pulse; gap_cnt <= GAP_CYCLES-1; state <= GAP, or IDLE if GAP_CYCLES == 0.
  - pwm_en is high for exactly NOTE_CYCLES cycles.
- GAP:
  - Count down; at 0 go to IDLE.
  - Hits arriving during GAP stay pending.
- mute=1 in LOAD or PLAY:
  - Next edge: pwm_en <= 0; note_done pulse; go to GAP (or IDLE).
  - mute in GAP or IDLE only clears pending.
- Latency: hit sampled at edge k → pending at k → grant at k+1 → LOAD cycle → pwm_en high after edge k+2.
- pad_top changes after the grant are ignored until the next grant.
- Counters are NOTE_CYCLES/GAP_CYCLES wide enough (clog2 of max+1); no wrap beyond the loaded value.
- busy is combinational from state.

Test Plan:
1. NOTE_CYCLES=8, GAP_CYCLES=2, pad_top[1]=100, single 1-cycle hit_req=0010 at edge 10:
   - pwm_restart high during cycle 11–12.
   - pwm_top=100 and active_pad=1 after edge 11.
   - pwm_en high after edge 12 for 8 cycles.
   - note_done one pulse; busy low 2 cycles later.
2. Simultaneous hit_req=1011 from reset, all tops valid:
   - Plays pads 0, 1, 3 in order, each 8 cycles on / 2 off.
   - rr_ptr ends at 0.
   - Then hit 1001: pad 0 plays before pad 3.
3. Pad 2 hit again during its own PLAY:
   - Exactly one re-play after the current note plus gap.
   - Two hits during PLAY still give only one re-play.
4. pad_top[0]=1, pad_top[1]=50, hit_req=0011:
   - skip_err pulses once; pwm_en never rises for pad 0.
   - Pad 1 plays with pwm_top=50; pwm_top stayed at its prior value during the skip.
5. mute pulsed at PLAY cycle 3 with pad 2 pending:
   - pwm_en low next edge; note_done pulse; pending=0.
   - IDLE after the gap, with no further notes.
6. rst asserted asynchronously mid-PLAY:
   - pwm_en, busy, and pending go to 0 immediately, without a clock edge.
   - After release, a new hit plays normally from rr_ptr=0.
